// File: rtl/inst_fetch_queue.sv
// Fetch queue: issues sequential PCs to the AXI read adapter and buffers returned words; response->inst_valid is 1 cycle (0 with FETCH_BYPASS_EN).
// Backpressure: inst_ready low holds the head; issue stalls once inflight+discard+occupancy reaches DEPTH.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        flush,
  output logic [31:0] address,
  output logic        address_valid,
  input  logic        address_read_ready,
  input  logic        data_valid,
  input  logic [31:0] data,
  input  logic [31:0] data_address,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   mem_inst [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];

  logic          fifo_empty;
  logic          accept;
  logic          resp_drop;
  logic          resp_keep;
  logic          bypass;
  logic          bypass_take;
  logic          fifo_push;
  logic          fifo_pop;
  logic          issue;
  logic [CW+1:0] credits_used;

  assign flush        = redirect_valid;
  assign fifo_empty   = (count == '0);
  assign accept       = address_valid && address_read_ready;
  assign resp_drop    = data_valid && (discard != '0);
  assign resp_keep    = data_valid && (discard == '0);
  assign credits_used = {2'b00, inflight} + {2'b00, discard} + {2'b00, count};
  assign issue        = !address_valid && !redirect_valid && (credits_used < (CW+2)'(DEPTH));

`ifdef FETCH_BYPASS_EN
  assign bypass = fifo_empty && (discard == '0) && !redirect_valid && data_valid;
`else
  assign bypass = 1'b0;
`endif

  assign bypass_take = bypass && inst_ready;
  assign inst_valid  = !fifo_empty || bypass;
  assign fifo_pop    = !fifo_empty && inst_ready && !redirect_valid;
  assign fifo_push   = resp_keep && !redirect_valid && !bypass_take;

  always_comb begin
    inst    = '0;
    inst_pc = '0;
    if (!fifo_empty) begin
      inst    = mem_inst[rd_ptr];
      inst_pc = mem_pc[rd_ptr];
    end else if (bypass) begin
      inst    = data;
      inst_pc = data_address;
    end
  end

  // pc advances at issue rather than acceptance, so a redirect that lands while
  // an old request is still pending is never overwritten when that request is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc            <= RESET_PC;
      address       <= RESET_PC;
      address_valid <= 1'b0;
    end else begin
      if (issue) begin
        address_valid <= 1'b1;
        address       <= pc;
      end else if (accept) begin
        address_valid <= 1'b0;
      end
      if (redirect_valid)
        pc <= redirect_pc;
      else if (issue)
        pc <= pc + 32'd4;
    end
  end

  // On redirect every outstanding request (including one still pending) becomes a discard.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= '0;
      discard  <= '0;
    end else if (redirect_valid) begin
      inflight <= '0;
      discard  <= discard - CW'(resp_drop) + inflight - CW'(resp_keep);
    end else begin
      inflight <= inflight + CW'(issue) - CW'(resp_keep);
      discard  <= discard - CW'(resp_drop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (redirect_valid) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(fifo_push) - CW'(fifo_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      mem_inst[wr_ptr] <= data;
      mem_pc[wr_ptr]   <= data_address;
    end
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: cycle vector table plus adapter-model sequences for backpressure, redirects and reset.
// Expectations depend on FETCH_BYPASS_EN where a response meets an empty FIFO.
module tb_inst_fetch_queue;
  localparam logic [31:0] RESET_PC = 32'hBFC00000;
`ifdef FETCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        flush;
  logic [31:0] address;
  logic        address_valid;
  logic        address_read_ready = 1'b0;
  logic        data_valid = 1'b0;
  logic [31:0] data = '0;
  logic [31:0] data_address = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .address(address), .address_valid(address_valid), .address_read_ready(address_read_ready),
    .data_valid(data_valid), .data(data), .data_address(data_address),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        arr;
    logic        dv;
    logic [31:0] d;
    logic [31:0] da;
    logic        ir;
    logic        e_av;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vt[16];

  function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic arr, input logic dv,
                              input logic [31:0] d, input logic [31:0] da, input logic ir, input logic e_av,
                              input logic [31:0] e_addr, input logic e_iv, input logic [31:0] e_inst,
                              input logic [31:0] e_ipc);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.arr = arr; v.dv = dv; v.d = d; v.da = da; v.ir = ir;
    v.e_av = e_av; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst; v.e_ipc = e_ipc;
    return v;
  endfunction

  // Adapter model: accepts in the first cycle address_valid is seen, returns ~addr after lat cycles.
  int          cyc;
  int          lat;
  logic        hold_arr;
  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] acc_addr[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];
  logic        s_flush, s_av, s_iv, s_dv;
  logic [31:0] s_ipc;

  task automatic auto_cycle(input logic rv, input logic [31:0] rpc, input logic ir);
    cyc++;
    address_read_ready = address_valid && !hold_arr;
    data_valid = 1'b0;
    if (q_due.size() > 0 && q_due[0] == cyc) begin
      data_valid   = 1'b1;
      data_address = q_addr[0];
      data         = ~q_addr[0];
      q_addr.delete(0);
      q_due.delete(0);
    end
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = ir;
    #1;
    s_flush = flush; s_av = address_valid; s_iv = inst_valid; s_ipc = inst_pc; s_dv = data_valid;
    if (address_read_ready) begin
      acc_addr.push_back(address);
      q_addr.push_back(address);
      q_due.push_back(cyc + lat);
    end
    if (inst_valid && inst_ready && !redirect_valid) begin
      got_pc.push_back(inst_pc);
      got_inst.push_back(inst);
    end
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic ir);
    for (int i = 0; i < n; i++) auto_cycle(1'b0, 32'h0, ir);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0; address_read_ready = 1'b0; data_valid = 1'b0; inst_ready = 1'b0;
    q_addr.delete(); q_due.delete(); acc_addr.delete(); got_pc.delete(); got_inst.delete();
    cyc = 0; lat = 2; hold_arr = 1'b0;
    s_flush = 1'b0; s_av = 1'b0; s_iv = 1'b0; s_dv = 1'b0; s_ipc = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_got(input string name, input int idx, input logic [31:0] exp_pc);
    if (got_pc.size() <= idx) begin
      checks++;
      errors++;
      $display("FAIL %s: only %0d words delivered, expected pc %h at index %0d", name, got_pc.size(), exp_pc, idx);
    end else begin
      chk32($sformatf("%s%0d_pc", name, idx), got_pc[idx], exp_pc);
      chk32($sformatf("%s%0d_inst", name, idx), got_inst[idx], ~exp_pc);
    end
  endtask

  task automatic chk_acc(input string name, input int idx, input logic [31:0] exp_addr);
    if (acc_addr.size() <= idx) begin
      checks++;
      errors++;
      $display("FAIL %s: only %0d requests accepted, expected %h at index %0d", name, acc_addr.size(), exp_addr, idx);
    end else begin
      chk32(name, acc_addr[idx], exp_addr);
    end
  endtask

  initial begin
    int found;
    // Cycle-by-cycle vectors starting the cycle reset is released.
    vt[0]  = mk(0, 0, 0, 0, 0, 0, 0,             0, 0,            0,    0, 0);
    vt[1]  = mk(0, 0, 1, 0, 0, 0, 1,             1, 32'hBFC00000, 0,    0, 0);
    vt[2]  = mk(0, 0, 0, 0, 0, 0, 1,             0, 0,            0,    0, 0);
    vt[3]  = mk(0, 0, 1, 1, 32'h11111111, 32'hBFC00000, 1, 1, 32'hBFC00004, BYP,  32'h11111111, 32'hBFC00000);
    vt[4]  = mk(0, 0, 0, 0, 0, 0, 1,             0, 0,            !BYP, 32'h11111111, 32'hBFC00000);
    vt[5]  = mk(0, 0, 1, 1, 32'h22222222, 32'hBFC00004, 1, 1, 32'hBFC00008, BYP,  32'h22222222, 32'hBFC00004);
    vt[6]  = mk(0, 0, 0, 0, 0, 0, 1,             0, 0,            !BYP, 32'h22222222, 32'hBFC00004);
    vt[7]  = mk(0, 0, 0, 1, 32'h33333333, 32'hBFC00008, 0, 1, 32'hBFC0000C, BYP,  32'h33333333, 32'hBFC00008);
    vt[8]  = mk(0, 0, 0, 0, 0, 0, 0,             1, 32'hBFC0000C, 1,    32'h33333333, 32'hBFC00008);
    vt[9]  = mk(1, 32'h80001000, 0, 0, 0, 0, 1,  1, 32'hBFC0000C, 1,    32'h33333333, 32'hBFC00008);
    vt[10] = mk(0, 0, 1, 0, 0, 0, 0,             1, 32'hBFC0000C, 0,    0, 0);
    vt[11] = mk(0, 0, 0, 0, 0, 0, 0,             0, 0,            0,    0, 0);
    vt[12] = mk(0, 0, 1, 1, 32'hDEADBEEF, 32'hBFC0000C, 1, 1, 32'h80001000, 0, 0, 0);
    vt[13] = mk(0, 0, 0, 0, 0, 0, 1,             0, 0,            0,    0, 0);
    vt[14] = mk(0, 0, 0, 1, 32'h44444444, 32'h80001000, 1, 1, 32'h80001004, BYP,  32'h44444444, 32'h80001000);
    vt[15] = mk(0, 0, 0, 0, 0, 0, 1,             1, 32'h80001004, !BYP, 32'h44444444, 32'h80001000);

    #1 reset = 1'b1;
    #2;
    chk1("rst_av", address_valid, 1'b0);
    chk32("rst_addr", address, RESET_PC);
    chk1("rst_iv", inst_valid, 1'b0);
    chk32("rst_inst", inst, 32'h0);
    chk32("rst_inst_pc", inst_pc, 32'h0);
    chk1("rst_flush", flush, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      redirect_valid = vt[i].rv; redirect_pc = vt[i].rpc; address_read_ready = vt[i].arr;
      data_valid = vt[i].dv; data = vt[i].d; data_address = vt[i].da; inst_ready = vt[i].ir;
      #1;
      chk1($sformatf("v%0d_flush", i), flush, vt[i].rv);
      chk1($sformatf("v%0d_av", i), address_valid, vt[i].e_av);
      if (vt[i].e_av) chk32($sformatf("v%0d_addr", i), address, vt[i].e_addr);
      chk1($sformatf("v%0d_iv", i), inst_valid, vt[i].e_iv);
      if (vt[i].e_iv) begin
        chk32($sformatf("v%0d_inst", i), inst, vt[i].e_inst);
        chk32($sformatf("v%0d_inst_pc", i), inst_pc, vt[i].e_ipc);
      end
      @(negedge clk);
    end

    // Backpressure: credit limit caps outstanding requests at DEPTH.
    do_reset();
    run(20, 1'b0);
    chk32("bp_issued", acc_addr.size(), 32'd4);
    chk1("bp_av", s_av, 1'b0);
    chk1("bp_iv", s_iv, 1'b1);
    chk32("bp_head", s_ipc, RESET_PC);
    acc_addr.delete();
    run(12, 1'b1);
    for (int k = 0; k < 4; k++) chk_got("bp", k, RESET_PC + 32'(4 * k));
    chk_acc("bp_resume", 0, 32'hBFC00010);

    // Redirect with two requests in flight and a third pending on address_valid.
    do_reset();
    lat = 6;
    for (int i = 0; i < 40; i++) begin
      if (acc_addr.size() >= 2) hold_arr = 1'b1;
      auto_cycle(1'b0, 32'h0, 1'b1);
      if (hold_arr && s_av) break;
    end
    chk1("rd_pend_av", s_av, 1'b1);
    chk32("rd_acc_before", acc_addr.size(), 32'd2);
    got_pc.delete(); got_inst.delete();
    auto_cycle(1'b1, 32'h80001000, 1'b1);
    chk1("rd_flush_hi", s_flush, 1'b1);
    auto_cycle(1'b0, 32'h0, 1'b1);
    chk1("rd_flush_lo", s_flush, 1'b0);
    chk1("rd_iv_empty", s_iv, 1'b0);
    hold_arr = 1'b0;
    run(40, 1'b1);
    chk_acc("rd_stale_acc", 2, 32'hBFC00008);
    chk_acc("rd_new_acc", 3, 32'h80001000);
    chk_got("rd", 0, 32'h80001000);
    chk_got("rd", 1, 32'h80001004);

    // Redirect coinciding with a response and a pop of a non-empty FIFO.
    do_reset();
    found = 0;
    for (int i = 0; i < 30; i++) begin
      if (s_iv && q_due.size() > 0 && q_due[0] == cyc + 1) begin
        found = 1;
        break;
      end
      auto_cycle(1'b0, 32'h0, 1'b0);
    end
    chk32("ds_found", found, 32'd1);
    got_pc.delete(); got_inst.delete();
    auto_cycle(1'b1, 32'h80004000, 1'b1);
    chk1("ds_dv", s_dv, 1'b1);
    chk1("ds_flush", s_flush, 1'b1);
    run(60, 1'b1);
    for (int k = 0; k < 6; k++) chk_got("ds", k, 32'h80004000 + 32'(4 * k));

    // Back-to-back redirects.
    do_reset();
    run(5, 1'b1);
    got_pc.delete(); got_inst.delete();
    auto_cycle(1'b1, 32'h80002000, 1'b1);
    auto_cycle(1'b1, 32'h80003000, 1'b1);
    run(30, 1'b1);
    chk_got("dr", 0, 32'h80003000);
    chk_got("dr", 1, 32'h80003004);

    // Asynchronous reset mid-stream: three words buffered, fourth request pending.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      if (acc_addr.size() >= 3) hold_arr = 1'b1;
      auto_cycle(1'b0, 32'h0, 1'b0);
    end
    chk1("ra_pre_av", s_av, 1'b1);
    chk1("ra_pre_iv", s_iv, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk1("ra_av", address_valid, 1'b0);
    chk1("ra_iv", inst_valid, 1'b0);
    chk32("ra_inst_pc", inst_pc, 32'h0);
    do_reset();
    run(20, 1'b1);
    chk_acc("ra_restart", 0, RESET_PC);
    chk_got("ra", 0, RESET_PC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
